spi_cfg_master: RTL and testbench

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/spi_cfg_master.sv | 136 +++++++++++++
 tb/tb_spi_cfg_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// Write-only SPI configuration master: 2-entry request FIFO feeding 16-bit
// LSB-first frames (bit15 = write flag, bits14:8 = addr, bits7:0 = data).
module spi_cfg_master #(
    parameter int DIV = 4,
    parameter int GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       cs,
    output logic       sclk,
    output logic       copi,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAPW} state_t;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
    localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

    state_t      state_q, state_n;
    logic [7:0]  phase_q, phase_n;
    logic [4:0]  bit_q, bit_n;
    logic [15:0] shift_q, shift_n;
    logic [14:0] fifo_q [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count_q, count_n;
    logic        push, pop, last;
    logic        cs_n, sclk_n, copi_n, busy_n, done_n, ready_n;

    assign push = req_valid && req_ready;
    assign last = (phase_q == 8'd0);

    // State, counters, FIFO pointers and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= 8'd0;
            bit_q     <= 5'd0;
            shift_q   <= 16'd0;
            count_q   <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state_q   <= state_n;
            phase_q   <= phase_n;
            bit_q     <= bit_n;
            shift_q   <= shift_n;
            count_q   <= count_n;
            wr_ptr    <= wr_ptr ^ push;
            rd_ptr    <= rd_ptr ^ pop;
            cs        <= cs_n;
            sclk      <= sclk_n;
            copi      <= copi_n;
            busy      <= busy_n;
            done      <= done_n;
            req_ready <= ready_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= {req_addr, req_data};
    end

    always_comb begin
        state_n = state_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    state_n = SETUP;
                    pop     = 1'b1;
                end
            end
            SETUP: if (last) state_n = HIGH;
            HIGH: begin
                if (last) begin
                    bit_n = bit_q + 5'd1;
                    if (bit_q == 5'd15) begin
                        state_n = HOLD;
                    end else begin
                        state_n = LOW;
                        shift_n = {1'b0, shift_q[15:1]};
                    end
                end
            end
            LOW:  if (last) state_n = HIGH;
            HOLD: if (last) state_n = GAPW;
            GAPW: begin
                if (last) begin
                    if (count_q != 2'd0) begin
                        state_n = SETUP;
                        pop     = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (pop) begin
            shift_n = {1'b1, fifo_q[rd_ptr]};
            bit_n   = 5'd0;
        end
        if (state_n != state_q)
            phase_n = (state_n == GAPW) ? GAP_M1 : DIV_M1;
        else if (!last)
            phase_n = phase_q - 8'd1;
        else
            phase_n = phase_q;
        count_n = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Outputs decoded from next state so they come straight off flops
    always_comb begin
        cs_n    = !(state_n inside {SETUP, HIGH, LOW, HOLD});
        sclk_n  = (state_n == HIGH);
        copi_n  = !cs_n && shift_n[0];
        done_n  = (state_n == GAPW) && (phase_n == 8'd0);
        busy_n  = (state_n != IDLE) || (count_n != 2'd0);
        ready_n = (count_n != 2'd2);
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: frame table, back-to-back queueing,
// reset abort and first-edge acceptance after reset.
module tb_spi_cfg_master;

    localparam int DIV = 4;
    localparam int GAP = 4;
    localparam int CSLOW = 33 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       cs, sclk, copi, busy, done;

    spi_cfg_master #(.DIV(DIV), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .cs(cs), .sclk(sclk), .copi(copi),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] frame;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Peripheral-side monitor state
    logic [15:0] rx;
    int nb = 0, rises = 0, lowcnt = 0, highcnt = 0, seen = 0;
    logic [15:0] frames [$];
    int lows [$];
    int gaps [$];
    int dones [$];

    always @(posedge sclk) begin
        rises++;
        if (cs === 1'b0) begin
            rx = {copi, rx[15:1]};
            nb++;
        end
    end

    always @(posedge cs) begin
        frames.push_back(rx);
        nb = 0;
    end

    always @(negedge clk) begin
        if (cs === 1'b0) begin
            if (highcnt != 0 && seen != 0) gaps.push_back(highcnt);
            highcnt = 0;
            lowcnt++;
        end else begin
            if (lowcnt != 0) begin
                lows.push_back(lowcnt);
                seen = 1;
            end
            lowcnt = 0;
            highcnt++;
        end
        if (done === 1'b1) dones.push_back(highcnt);
    end

    task automatic clear_mon();
        frames.delete();
        lows.delete();
        gaps.delete();
        dones.delete();
        lowcnt = 0;
        highcnt = 0;
        seen = 0;
        nb = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the accept edge
    task automatic push(input logic [6:0] a, input logic [7:0] d,
                        output int waited);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_dones(input int n);
        int k = 0;
        while (dones.size() < n && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_wait", 32'(dones.size() >= n), 32'd1);
    endtask

    vec_t vecs [6];
    logic [15:0] b2b [4];

    initial begin
        int w, prev, r0, r1, r2, k;

        vecs[0] = '{7'h04, 8'h80, 16'h8480};
        vecs[1] = '{7'h00, 8'hA5, 16'h80A5};
        vecs[2] = '{7'h7F, 8'hFF, 16'hFFFF};
        vecs[3] = '{7'h05, 8'hFF, 16'h85FF};
        vecs[4] = '{7'h55, 8'h00, 16'hD500};
        vecs[5] = '{7'h2A, 8'h3C, 16'hAA3C};
        b2b[0] = 16'h8111;
        b2b[1] = 16'h8222;
        b2b[2] = 16'h8333;
        b2b[3] = 16'h8444;

        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = 7'h0;
        req_data = 8'h0;
        rx = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_copi", 32'(copi), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        clear_mon();

        for (int i = 0; i < 6; i++) begin
            prev = dones.size();
            push(vecs[i].addr, vecs[i].data, w);
            wait_dones(prev + 1);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("frame%0d", i), 32'(frames[$]), 32'(vecs[i].frame));
            check($sformatf("cslow%0d", i), 32'(lows[$]), CSLOW);
            check($sformatf("donepos%0d", i), 32'(dones[$]), GAP);
            check($sformatf("donecnt%0d", i), 32'(dones.size()), 32'(prev + 1));
            check($sformatf("idle%0d", i), 32'({busy, cs}), 32'b01);
        end

        // Three consecutive requests from idle, then a fourth that must stall
        clear_mon();
        r0 = 32'(req_ready);
        push(7'h01, 8'h11, w);
        r1 = 32'(req_ready);
        push(7'h02, 8'h22, w);
        r2 = 32'(req_ready);
        push(7'h03, 8'h33, w);
        check("b2b_ready_kept", 32'({r0[0], r1[0], r2[0]}), 32'b111);
        check("b2b_full", 32'(req_ready), 32'd0);
        push(7'h04, 8'h44, w);
        check("b2b_stall", 32'(w), 32'(CSLOW + GAP - 1));
        wait_dones(4);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_nframes", 32'(frames.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_frame%0d", i), 32'(frames[i]), 32'(b2b[i]));
            check($sformatf("b2b_cslow%0d", i), 32'(lows[i]), CSLOW);
        end
        check("b2b_ngaps", 32'(gaps.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_gap%0d", i), 32'(gaps[i]), GAP);

        // Reset in the middle of a frame with a second request queued
        rises = 0;
        push(7'h11, 8'h22, w);
        push(7'h33, 8'h44, w);
        k = 0;
        while (rises < 8 && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("abort_reached", 32'(rises), 32'd8);
        rst = 1'b1;
        #1;
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        repeat (400) @(posedge clk);
        #1;
        check("abort_noframe", 32'(frames.size() + lows.size()), 32'd0);
        check("abort_idle", 32'({busy, cs}), 32'b01);

        // Request presented during reset is taken on the first edge after it
        rst = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr = 7'h5A;
        req_data = 8'hC3;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("first_edge_accept", 32'(busy), 32'd1);
        clear_mon();
        wait_dones(1);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_frame", 32'(frames[$]), 32'h0000DAC3);
        check("post_rst_cslow", 32'(lows[$]), CSLOW);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
